// File: rtl/async_reset_fifo_if.sv
// Handshake bundle between the FIFO bench driver/receiver and async_reset_fifo.
// master = bench side, slave = FIFO side.
// FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow signals.
interface async_reset_fifo_if #(
   parameter int WIDTH        = 8,
   parameter int POINTER_SIZE = 5
) ();
   logic                    write_enb;
   logic                    read_enb;
   logic [WIDTH-1:0]        data_in;
   logic [WIDTH-1:0]        data_out;
   logic                    empty;
   logic                    full;
   logic [POINTER_SIZE-1:0] fill_level;
`ifdef FIFO_ERR_FLAGS_EN
   logic                    overflow;
   logic                    underflow;

   modport master (
      output write_enb, read_enb, data_in,
      input  data_out, empty, full, fill_level, overflow, underflow
   );
   modport slave (
      input  write_enb, read_enb, data_in,
      output data_out, empty, full, fill_level, overflow, underflow
   );
`else
   modport master (
      output write_enb, read_enb, data_in,
      input  data_out, empty, full, fill_level
   );
   modport slave (
      input  write_enb, read_enb, data_in,
      output data_out, empty, full, fill_level
   );
`endif
endinterface

// File: rtl/async_reset_fifo.sv
// Single-clock FIFO with asynchronous active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// flags and fill level are decoded from the registered pointers.
// Optional: define FIFO_ERR_FLAGS_EN for sticky overflow/underflow outputs.
module async_reset_fifo #(
   parameter int WIDTH        = 8,
   parameter int DEPTH        = 16,
   parameter int POINTER_SIZE = 5
) (
   input logic                clock,
   input logic                resetn,
   async_reset_fifo_if.slave  bus
);

   localparam int ADDR_W = POINTER_SIZE - 1;

   generate
      if (POINTER_SIZE != $clog2(DEPTH) + 1) begin : g_bad_ptr_size
         $error("async_reset_fifo: POINTER_SIZE must equal log2(DEPTH)+1");
      end
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("async_reset_fifo: DEPTH must be a power of two >= 2");
      end
   endgenerate

   logic [WIDTH-1:0]        mem [DEPTH];
   logic [POINTER_SIZE-1:0] wr_ptr;
   logic [POINTER_SIZE-1:0] rd_ptr;
   logic [WIDTH-1:0]        data_q;
   logic                    empty_w;
   logic                    full_w;
   logic                    wr_acc;
   logic                    rd_acc;

   assign empty_w = (wr_ptr == rd_ptr);
   assign full_w  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   // Reads never bypass a same-cycle write, so both gates use the registered flags.
   assign wr_acc = bus.write_enb && !full_w;
   assign rd_acc = bus.read_enb && !empty_w;

   assign bus.empty      = empty_w;
   assign bus.full       = full_w;
   assign bus.fill_level = wr_ptr - rd_ptr;
   assign bus.data_out   = data_q;

   // Storage array; intentionally not reset, stale entries are unreachable after reset.
   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
      end
   end

   // Write pointer advances once per accepted write and wraps naturally.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
      end else if (wr_acc) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Read pointer and registered read data; data_out holds when no read is accepted.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         data_q <= '0;
      end else if (rd_acc) begin
         rd_ptr <= rd_ptr + 1'b1;
         data_q <= mem[rd_ptr[ADDR_W-1:0]];
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_enb && full_w) begin
            overflow_q <= 1'b1;
         end
         if (bus.read_enb && empty_w) begin
            underflow_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_async_reset_fifo.sv
// Directed bench for async_reset_fifo: reset, single word, fill/overflow,
// simultaneous access at the boundaries, pointer wrap, and mid-cycle async reset.
module tb_async_reset_fifo;

   logic clock;
   logic resetn;
   int   total;
   int   bad;

   async_reset_fifo_if #(.WIDTH(8), .POINTER_SIZE(5)) bus ();

   async_reset_fifo #(.WIDTH(8), .DEPTH(16), .POINTER_SIZE(5)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive for one rising edge, return at the next negedge.
   task automatic cyc(input logic we, input logic re, input logic [7:0] din);
      bus.write_enb = we;
      bus.read_enb  = re;
      bus.data_in   = din;
      @(posedge clock);
      @(negedge clock);
      bus.write_enb = 1'b0;
      bus.read_enb  = 1'b0;
      bus.data_in   = 'x;
   endtask

   logic [7:0] words [16];
   logic [7:0] exp_q [$];

   initial begin
      total = 0;
      bad   = 0;
      bus.write_enb = 1'b0;
      bus.read_enb  = 1'b0;
      bus.data_in   = 'x;
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_data_out", 32'(bus.data_out), 32'h00);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_fill", 32'(bus.fill_level), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      chk("rst_udf", 32'(bus.underflow), 32'd0);
`endif
      resetn = 1'b1;

      // single word through
      cyc(1'b1, 1'b0, 8'd85);
      chk("one_fill", 32'(bus.fill_level), 32'd1);
      chk("one_empty", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      chk("one_data", 32'(bus.data_out), 32'd85);
      chk("one_empty2", 32'(bus.empty), 32'd1);
      chk("one_fill2", 32'(bus.fill_level), 32'd0);

      // X on data_in with write_enb low must not change state
      cyc(1'b0, 1'b0, 8'hxx);
      chk("x_fill", 32'(bus.fill_level), 32'd0);

      // fill to 16
      for (int i = 0; i < 16; i++) begin
         words[i] = 8'(8'h10 + i * 3);
         cyc(1'b1, 1'b0, words[i]);
      end
      chk("full_flag", 32'(bus.full), 32'd1);
      chk("full_fill", 32'(bus.fill_level), 32'd16);
      cyc(1'b1, 1'b0, 8'hAA);
      chk("drop_full", 32'(bus.full), 32'd1);
      chk("drop_fill", 32'(bus.fill_level), 32'd16);
      chk("drop_data", 32'(bus.data_out), 32'd85);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_set", 32'(bus.overflow), 32'd1);
      chk("udf_clear", 32'(bus.underflow), 32'd0);
`endif
      // both while full: read accepted, write dropped
      cyc(1'b1, 1'b1, 8'hAA);
      chk("both_full_data", 32'(bus.data_out), 32'(words[0]));
      chk("both_full_fill", 32'(bus.fill_level), 32'd15);
      chk("both_full_flag", 32'(bus.full), 32'd0);
      for (int i = 1; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk($sformatf("drain16_%0d", i), 32'(bus.data_out), 32'(words[i]));
      end
      chk("drain16_empty", 32'(bus.empty), 32'd1);

      // read on empty: ignored
      cyc(1'b0, 1'b1, 8'h00);
      chk("rd_empty_data", 32'(bus.data_out), 32'h3D);
      chk("rd_empty_fill", 32'(bus.fill_level), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("udf_set", 32'(bus.underflow), 32'd1);
`endif

      // both while empty: write only, no bypass
      cyc(1'b1, 1'b1, 8'h55);
      chk("both_empty_data", 32'(bus.data_out), 32'h3D);
      chk("both_empty_fill", 32'(bus.fill_level), 32'd1);
      chk("both_empty_flag", 32'(bus.empty), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      chk("both_empty_read", 32'(bus.data_out), 32'h55);

      // fill to 3, then 20 simultaneous cycles across the pointer wrap
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         exp_q.push_back(8'(i));
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 8'd170);
         exp_q.push_back(8'd170);
         chk("wrap_pop", 32'(bus.data_out), 32'(exp_q.pop_front()));
         chk("wrap_fill", 32'(bus.fill_level), 32'd3);
      end
      while (exp_q.size() > 0) begin
         cyc(1'b0, 1'b1, 8'h00);
         chk("wrap_drain", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
      chk("wrap_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_hold", 32'(bus.overflow), 32'd1);
      chk("udf_hold", 32'(bus.underflow), 32'd1);
`endif

      // fill to 5, then async reset between edges
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
      chk("pre_rst_fill", 32'(bus.fill_level), 32'd5);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_empty", 32'(bus.empty), 32'd1);
      chk("arst_fill", 32'(bus.fill_level), 32'd0);
      chk("arst_data", 32'(bus.data_out), 32'd0);
      chk("arst_full", 32'(bus.full), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
      chk("arst_ovf", 32'(bus.overflow), 32'd0);
      chk("arst_udf", 32'(bus.underflow), 32'd0);
`endif
      @(negedge clock);
      resetn = 1'b1;
      cyc(1'b0, 1'b1, 8'h00);
      chk("post_rst_data", 32'(bus.data_out), 32'd0);
      chk("post_rst_empty", 32'(bus.empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
